microcode_sequencer: RTL and testbench

Writable-control-store microcode sequencer: holds a bootstrap-loaded control store of 2^(OPCODE_BITS+UOP_BITS) words of WIDTH bits, owns the opcode register and micro-op counter, and presents the registered control word for the current {opcode, micro-op} to control logic. It generalises the fixed microcode lookup in three ways: parameterised geometry, an internal micro-op counter with self-reset, and stall support. It sits between the bootstrap loader and the control logic that decodes control-word planes.

---
 rtl/microcode_sequencer_if.sv | 34 +++
 rtl/microcode_sequencer.sv | 118 +++++++++++
 tb/tb_microcode_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_if.sv
// Signal bundle between the sequencer (slave) and the loader/control side (master).
// OUT is qualified by OUT_VALID; there is no back-pressure other than STALL.
interface microcode_sequencer_if #(
    parameter int OPCODE_BITS = 6,
    parameter int UOP_BITS    = 5,
    parameter int WIDTH       = 32,
    parameter int LANE_BITS   = 2
);
    logic                                      N_BOOTED;
    logic [OPCODE_BITS+UOP_BITS+LANE_BITS-1:0] BOOTSTRAP_ADDR;
    logic [7:0]                                BOOTSTRAP_DATA;
    logic                                      BOOTSTRAP_N_WE;
    logic                                      STALL;
    logic                                      OPCODE_WE;
    logic [OPCODE_BITS-1:0]                    OPCODE_IN;
    logic [WIDTH-1:0]                          OUT;
    logic                                      OUT_VALID;
    logic [OPCODE_BITS-1:0]                    OPCODE;
    logic [UOP_BITS-1:0]                       UOP;
    logic                                      UOP_OVF;
    logic [1:0]                                DBG_STATE;

    modport master (
        output N_BOOTED, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE,
        output STALL, OPCODE_WE, OPCODE_IN,
        input  OUT, OUT_VALID, OPCODE, UOP, UOP_OVF, DBG_STATE
    );

    modport slave (
        input  N_BOOTED, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE,
        input  STALL, OPCODE_WE, OPCODE_IN,
        output OUT, OUT_VALID, OPCODE, UOP, UOP_OVF, DBG_STATE
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Writable-control-store microcode sequencer: byte-loaded store, opcode register,
// self-resetting micro-op counter with stall, registered control word output.
module microcode_sequencer #(
    parameter int OPCODE_BITS = 6,
    parameter int UOP_BITS    = 5,
    parameter int WIDTH       = 32,
    parameter int RESET_BIT   = 15
) (
    input  logic                 CLK,
    input  logic                 N_RST,
    microcode_sequencer_if.slave bus
);
    localparam int BYTES     = WIDTH / 8;
    localparam int LANE_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int WORD_BITS = OPCODE_BITS + UOP_BITS;
    localparam int DEPTH     = 1 << WORD_BITS;
    localparam int ADDR_BITS = WORD_BITS + LANE_BITS;

    typedef enum logic [1:0] {
        S_HELD  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OPCODE_BITS-1:0] opcode_q, opcode_d;
    logic [UOP_BITS-1:0]    uop_q, uop_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   ovf_q, ovf_d;

    logic [WIDTH-1:0]       store_q [DEPTH];

    logic [WORD_BITS-1:0]   wr_word;
    logic [ADDR_BITS-1:0]   wr_lane;
    logic                   wr_en;

    // Byte address splits into word index (upper bits) and lane (low bits).
    assign wr_word = WORD_BITS'(bus.BOOTSTRAP_ADDR >> LANE_BITS);
    assign wr_lane = bus.BOOTSTRAP_ADDR & ADDR_BITS'(BYTES - 1);
    assign wr_en   = (state_q == S_HELD) && !bus.BOOTSTRAP_N_WE;

    // Store contents survive reset; only the loader defines them.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_lane == ADDR_BITS'(b)) begin
                    store_q[wr_word][b*8 +: 8] <= bus.BOOTSTRAP_DATA;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q  <= S_HELD;
            opcode_q <= '0;
            uop_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            uop_q    <= uop_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    // The store is read with the next {opcode, uop}, so OUT tracks the current state.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        uop_d    = uop_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_HELD: begin
                opcode_d = '0;
                uop_d    = '0;
                out_d    = '0;
                ovf_d    = 1'b0;
                if (!bus.N_BOOTED) state_d = S_PRIME;
            end
            S_PRIME: begin
                opcode_d = '0;
                uop_d    = '0;
                out_d    = store_q[WORD_BITS'(0)];
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (bus.N_BOOTED) begin
                    state_d  = S_HELD;
                    opcode_d = '0;
                    uop_d    = '0;
                    out_d    = '0;
                    ovf_d    = 1'b0;
                end else if (!bus.STALL) begin
                    if (out_q[RESET_BIT]) begin
                        uop_d = '0;
                    end else begin
                        uop_d = uop_q + UOP_BITS'(1);
                        if (&uop_q) ovf_d = 1'b1;
                    end
                    if (bus.OPCODE_WE) opcode_d = bus.OPCODE_IN;
                    out_d = store_q[{opcode_d, uop_d}];
                end
            end
            default: state_d = S_HELD;
        endcase
    end

    assign bus.OUT       = out_q;
    assign bus.OUT_VALID = (state_q == S_RUN);
    assign bus.OPCODE    = opcode_q;
    assign bus.UOP       = uop_q;
    assign bus.UOP_OVF   = ovf_q;
    assign bus.DBG_STATE = state_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the sequencer.
module tb_microcode_sequencer;
    localparam int OB    = 6;
    localparam int UB    = 5;
    localparam int W     = 32;
    localparam int LB    = 2;
    localparam int RB    = 15;
    localparam int NUOP  = 1 << UB;
    localparam int DEPTH = 1 << (OB + UB);

    logic CLK = 1'b0;
    logic N_RST = 1'b0;
    always #5 CLK = ~CLK;

    microcode_sequencer_if #(.OPCODE_BITS(OB), .UOP_BITS(UB), .WIDTH(W), .LANE_BITS(LB)) sq_if ();

    microcode_sequencer #(.OPCODE_BITS(OB), .UOP_BITS(UB), .WIDTH(W), .RESET_BIT(RB)) dut (
        .CLK   (CLK),
        .N_RST (N_RST),
        .bus   (sq_if)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural model: phase 0 = held, 1 = priming, 2 = running.
    int         m_phase;
    int         m_op;
    int         m_uop;
    bit         m_ovf;
    logic [W-1:0] m_out;
    logic [W-1:0] m_store [DEPTH];

    typedef struct {
        bit         stall;
        bit         we;
        logic [5:0] op_in;
        int         e_op;
        int         e_uop;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_op  = 0;
        m_uop = 0;
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        int word;
        int lane;
        if (m_phase == 0) begin
            if (!sq_if.BOOTSTRAP_N_WE) begin
                word = int'(sq_if.BOOTSTRAP_ADDR) / (W / 8);
                lane = int'(sq_if.BOOTSTRAP_ADDR) % (W / 8);
                m_store[word][lane*8 +: 8] = sq_if.BOOTSTRAP_DATA;
            end
            model_clear();
            if (!sq_if.N_BOOTED) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_op    = 0;
            m_uop   = 0;
            m_out   = m_store[0];
        end else if (sq_if.N_BOOTED) begin
            m_phase = 0;
            model_clear();
        end else if (!sq_if.STALL) begin
            if (m_out[RB]) begin
                m_uop = 0;
            end else begin
                if (m_uop == NUOP - 1) m_ovf = 1'b1;
                m_uop = (m_uop + 1) % NUOP;
            end
            if (sq_if.OPCODE_WE) m_op = int'(sq_if.OPCODE_IN);
            m_out = m_store[m_op * NUOP + m_uop];
        end
        exp_q.push_back(m_out);
    endtask

    task automatic check_all();
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("out", sq_if.OUT, e);
        check("out_valid", 32'(sq_if.OUT_VALID), 32'(m_phase == 2));
        check("opcode", 32'(sq_if.OPCODE), 32'(m_op));
        check("uop", 32'(sq_if.UOP), 32'(m_uop));
        check("uop_ovf", 32'(sq_if.UOP_OVF), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic write_byte(input int addr, input logic [7:0] data, input bit boot_fall);
        sq_if.BOOTSTRAP_ADDR = (OB + UB + LB)'(addr);
        sq_if.BOOTSTRAP_DATA = data;
        sq_if.BOOTSTRAP_N_WE = 1'b0;
        sq_if.N_BOOTED       = !boot_fall;
        step();
        sq_if.BOOTSTRAP_N_WE = 1'b1;
    endtask

    task automatic write_word(input int word, input logic [W-1:0] data, input bit boot_fall);
        for (int b = 0; b < W / 8; b++) begin
            write_byte(word * (W / 8) + b, data[b*8 +: 8], boot_fall && (b == W / 8 - 1));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out"}, sq_if.OUT, 32'h0);
        check({tag, "_valid"}, 32'(sq_if.OUT_VALID), 32'h0);
        check({tag, "_opcode"}, 32'(sq_if.OPCODE), 32'h0);
        check({tag, "_uop"}, 32'(sq_if.UOP), 32'h0);
        check({tag, "_ovf"}, 32'(sq_if.UOP_OVF), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int grp;

        tbl[0] = '{stall: 1'b0, we: 1'b0, op_in: 6'd0, e_op: 0, e_uop: 1};
        tbl[1] = '{stall: 1'b0, we: 1'b0, op_in: 6'd0, e_op: 0, e_uop: 2};
        tbl[2] = '{stall: 1'b1, we: 1'b1, op_in: 6'd7, e_op: 0, e_uop: 2};
        tbl[3] = '{stall: 1'b1, we: 1'b1, op_in: 6'd7, e_op: 0, e_uop: 2};
        tbl[4] = '{stall: 1'b1, we: 1'b1, op_in: 6'd7, e_op: 0, e_uop: 2};
        tbl[5] = '{stall: 1'b0, we: 1'b0, op_in: 6'd0, e_op: 0, e_uop: 3};
        tbl[6] = '{stall: 1'b0, we: 1'b1, op_in: 6'd1, e_op: 1, e_uop: 0};

        sq_if.N_BOOTED       = 1'b1;
        sq_if.BOOTSTRAP_ADDR = '0;
        sq_if.BOOTSTRAP_DATA = '0;
        sq_if.BOOTSTRAP_N_WE = 1'b1;
        sq_if.STALL          = 1'b0;
        sq_if.OPCODE_WE      = 1'b0;
        sq_if.OPCODE_IN      = '0;
        m_phase = 0;
        model_clear();

        #12;
        check_zero_outputs("reset");
        @(negedge CLK);
        N_RST = 1'b1;

        // Define every store word; opcodes 2 and 3 never set the reset bit.
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            grp = w / NUOP;
            if (grp == 2 || grp == 3) d[RB] = 1'b0;
            write_word(w, d, 1'b0);
        end
        write_byte(0, 8'h44, 1'b0);
        write_byte(1, 8'h33, 1'b0);
        write_byte(2, 8'h22, 1'b0);
        write_byte(3, 8'h11, 1'b0);
        write_word(3 * NUOP + 5, 32'h11223344, 1'b0);
        write_byte((3 * NUOP + 5) * 4 + 2, 8'hAB, 1'b0);
        d = $urandom; d[RB] = 1'b0; write_word(1, d, 1'b0);
        d = $urandom; d[RB] = 1'b0; write_word(2, d, 1'b0);
        // Last byte of word 3 lands on the same edge N_BOOTED falls.
        d = $urandom; d[RB] = 1'b1; write_word(3, d, 1'b1);

        sq_if.N_BOOTED = 1'b0;
        check("prime_valid", 32'(sq_if.OUT_VALID), 32'h0);
        step();
        check("first_out", sq_if.OUT, 32'h11223344);
        check("first_valid", 32'(sq_if.OUT_VALID), 32'h1);
        check("first_uop", 32'(sq_if.UOP), 32'h0);

        for (int i = 0; i < 7; i++) begin
            sq_if.STALL     = tbl[i].stall;
            sq_if.OPCODE_WE = tbl[i].we;
            sq_if.OPCODE_IN = tbl[i].op_in;
            step();
            check($sformatf("tbl%0d_op", i), 32'(sq_if.OPCODE), 32'(tbl[i].e_op));
            check($sformatf("tbl%0d_uop", i), 32'(sq_if.UOP), 32'(tbl[i].e_uop));
        end
        check("tbl_out_op1", sq_if.OUT, m_store[NUOP]);
        sq_if.STALL     = 1'b0;
        sq_if.OPCODE_WE = 1'b0;

        // Switch to opcode 2 (no reset bit anywhere) and let the counter wrap.
        sq_if.OPCODE_WE = 1'b1;
        sq_if.OPCODE_IN = 6'd2;
        step();
        sq_if.OPCODE_WE = 1'b0;
        for (int i = 0; i < 2 * NUOP && !(m_uop == 0 && m_ovf); i++) step();
        check("wrap_uop", 32'(sq_if.UOP), 32'h0);
        check("wrap_ovf", 32'(sq_if.UOP_OVF), 32'h1);
        for (int i = 0; i < 5; i++) step();
        check("ovf_sticky", 32'(sq_if.UOP_OVF), 32'h1);

        // Bootstrap write while running must not reach the store.
        sq_if.BOOTSTRAP_ADDR = (OB + UB + LB)'((3 * NUOP + 5) * 4 + 2);
        sq_if.BOOTSTRAP_DATA = 8'h00;
        sq_if.BOOTSTRAP_N_WE = 1'b0;
        sq_if.OPCODE_WE      = 1'b1;
        sq_if.OPCODE_IN      = 6'd3;
        step();
        sq_if.BOOTSTRAP_N_WE = 1'b1;
        sq_if.OPCODE_WE      = 1'b0;
        for (int i = 0; i < 2 * NUOP && !(m_op == 3 && m_uop == 5); i++) step();
        check("lane_word", sq_if.OUT, 32'h11AB3344);

        sq_if.N_BOOTED = 1'b1;
        step();
        check("held_ovf_clear", 32'(sq_if.UOP_OVF), 32'h0);
        check("held_valid", 32'(sq_if.OUT_VALID), 32'h0);

        // Asynchronous reset in the middle of running.
        sq_if.N_BOOTED = 1'b0;
        for (int i = 0; i < 6; i++) step();
        N_RST = 1'b0;
        #1;
        m_phase = 0;
        model_clear();
        check_zero_outputs("async_rst");
        sq_if.N_BOOTED = 1'b1;
        @(negedge CLK);
        N_RST = 1'b1;
        sq_if.N_BOOTED = 1'b0;
        step();
        step();
        check("reboot_out", sq_if.OUT, 32'h11223344);
        check("reboot_valid", 32'(sq_if.OUT_VALID), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            sq_if.N_BOOTED       = ($urandom_range(0, 99) < 3);
            sq_if.STALL          = ($urandom_range(0, 3) == 0);
            sq_if.OPCODE_WE      = ($urandom_range(0, 4) == 0);
            sq_if.OPCODE_IN      = OB'($urandom);
            sq_if.BOOTSTRAP_N_WE = 1'($urandom_range(0, 1));
            sq_if.BOOTSTRAP_ADDR = (OB + UB + LB)'($urandom);
            sq_if.BOOTSTRAP_DATA = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
